// File: rtl/beep_pkg.sv
// Shared types and constants for the alarm-beep scheduler.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } beep_st_t;

  localparam int REQ_OT  = 0;
  localparam int REQ_UT  = 1;
  localparam int REQ_KEY = 2;
  localparam int NREQ    = 3;
  localparam int MS_W    = 10;

  // Fixed priority: lowest set index wins.
  function automatic logic [1:0] first_set(input logic [NREQ-1:0] v);
    if (v[REQ_OT])      return 2'(REQ_OT);
    else if (v[REQ_UT]) return 2'(REQ_UT);
    else                return 2'(REQ_KEY);
  endfunction

endpackage

// File: rtl/beep_phase_timer.sv
// Millisecond phase timer: prescaler plus ms counter, cleared on start.
module beep_phase_timer import beep_pkg::*; #(
  parameter int MS_DIV = 50_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [MS_W-1:0] len_ms,
  output logic            expire
);

  localparam int             PRE_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    ms_d  = ms_q;
    if (start) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d = '0;
      ms_d  = ms_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  assign expire = (pre_q == PRE_MAX) && (ms_q == len_ms - 1'b1);

endmodule

// File: rtl/beep_sched.sv
// Alarm-beep scheduler: pending latch, fixed-priority arbiter and burst FSM.
module beep_sched import beep_pkg::*; #(
  parameter int CLK_PRE = 50_000_000,
  parameter int MS_DIV  = CLK_PRE / 1000,
  parameter int ON0_MS  = 200,
  parameter int OFF0_MS = 200,
  parameter int CNT0    = 3,
  parameter int ON1_MS  = 100,
  parameter int OFF1_MS = 100,
  parameter int CNT1    = 2,
  parameter int ON2_MS  = 50,
  parameter int OFF2_MS = 50,
  parameter int CNT2    = 1,
  parameter int GAP_MS  = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            mute,
  input  logic            clr,
  output logic            beep_en,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done
);

  localparam logic [MS_W-1:0] ON_TAB  [NREQ] = '{MS_W'(ON0_MS),  MS_W'(ON1_MS),  MS_W'(ON2_MS)};
  localparam logic [MS_W-1:0] OFF_TAB [NREQ] = '{MS_W'(OFF0_MS), MS_W'(OFF1_MS), MS_W'(OFF2_MS)};
  localparam logic [3:0]      CNT_TAB [NREQ] = '{4'(CNT0), 4'(CNT1), 4'(CNT2)};
  localparam logic [MS_W-1:0] GAP_LEN        = MS_W'(GAP_MS);

  beep_st_t        state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d, take, grant_q, grant_d;
  logic [MS_W-1:0] on_q, on_d, off_q, off_d, len_ms;
  logic [3:0]      cnt_q, cnt_d, burst_q, burst_d;
  logic            beep_en_q, beep_en_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]      idx;
  logic            expire, start;

  assign idx = first_set(pend_q);

  always_comb begin
    case (state_q)
      ST_ON:   len_ms = on_q;
      ST_OFF:  len_ms = off_q;
      default: len_ms = GAP_LEN;
    endcase
  end

  // Counters restart on every state entry; holding them cleared while idle keeps ON aligned.
  assign start = clr | (state_d != state_q) | (state_q == ST_IDLE);

  beep_phase_timer #(.MS_DIV(MS_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len_ms (len_ms),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    on_d    = on_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    take    = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (|pend_q) begin
        take[idx] = 1'b1;
        grant_d   = NREQ'(1) << idx;
        on_d      = ON_TAB[idx];
        off_d     = OFF_TAB[idx];
        cnt_d     = CNT_TAB[idx];
        burst_d   = '0;
        state_d   = ST_ON;
      end
      ST_ON: if (expire) begin
        if (burst_q == cnt_q - 4'd1) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: if (expire) begin
        burst_d = burst_q + 4'd1;
        state_d = ST_ON;
      end
      ST_GAP: if (expire) begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new request wins over the arbitration clear of the same bit.
    pend_d = (pend_q & ~take) | req;
    if (clr) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      grant_d = '0;
      burst_d = '0;
      done_d  = 1'b0;
    end
    beep_en_d = (state_d == ST_ON) & ~mute;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      grant_q   <= '0;
      on_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      beep_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      on_q      <= on_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      beep_en_q <= beep_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign beep_en = beep_en_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_beep_sched.sv
// Bench for beep_sched: vector table, directed corner sequences, random traffic vs job-timeline model.
module tb_beep_sched;

  localparam int MSD   = 10;
  localparam int ON_C  [3] = '{200*MSD, 100*MSD, 50*MSD};
  localparam int OFF_C [3] = '{200*MSD, 100*MSD, 50*MSD};
  localparam int CNT_C [3] = '{3, 2, 1};
  localparam int GAP_C = 100*MSD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] req = '0;
  logic       mute = 1'b0;
  logic       clr = 1'b0;
  logic       beep_en, busy, done;
  logic [2:0] grant;

  int ntests = 0;
  int nfail  = 0;
  int rc     = 0;
  bit chk_en = 1'b0;

  beep_sched #(.CLK_PRE(10_000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mute    (mute),
    .clr     (clr),
    .beep_en (beep_en),
    .grant   (grant),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference: a job is a timeline offset t from its first ON cycle; outputs follow from arithmetic on t.
  bit         m_act;
  int         m_t, m_r;
  logic [2:0] m_pend;
  logic       exp_en, exp_busy, exp_done;
  logic [2:0] exp_grant;

  always @(posedge clk or negedge rst_n) begin : mdl
    int nt, nr, per, dt;
    bit nact;
    logic [2:0] np;
    if (!rst_n) begin
      m_act <= 1'b0; m_t <= 0; m_r <= 0; m_pend <= '0;
      exp_en <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0; exp_grant <= '0;
    end else begin
      nact = m_act; nt = m_t; nr = m_r; np = m_pend | req;
      if (clr) begin
        nact = 1'b0; np = '0;
      end else if (m_act) begin
        nt = m_t + 1;
        per = ON_C[m_r] + OFF_C[m_r];
        if (nt == (CNT_C[m_r]-1)*per + ON_C[m_r] + GAP_C) nact = 1'b0;
      end else if (m_pend != '0) begin
        nr = lowest(m_pend); nact = 1'b1; nt = 0;
        np = (m_pend & ~(3'b001 << nr)) | req;
      end
      per = ON_C[nr] + OFF_C[nr];
      dt  = (CNT_C[nr]-1)*per + ON_C[nr];
      exp_busy  <= nact;
      exp_grant <= nact ? (3'b001 << nr) : 3'b000;
      exp_done  <= nact && (nt == dt);
      exp_en    <= nact && (nt < dt) && ((nt % per) < ON_C[nr]) && !mute;
      m_act <= nact; m_t <= nt; m_r <= nr; m_pend <= np;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ntests++;
      if ({beep_en, grant, busy, done} !== {exp_en, exp_grant, exp_busy, exp_done}) begin
        nfail++;
        $display("FAIL model @%0t got en=%b grant=%b busy=%b done=%b want en=%b grant=%b busy=%b done=%b",
                 $time, beep_en, grant, busy, done, exp_en, exp_grant, exp_busy, exp_done);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic adv_to(input int k);
    while (rc < k) begin
      @(negedge clk);
      rc++;
    end
  endtask

  task automatic measure(input logic [2:0] r, input logic mu,
                         output int first_on, output int n_on, output int done_c, output int idle_c);
    bit seen;
    first_on = -1; n_on = 0; done_c = -1; idle_c = -1; seen = 1'b0;
    @(negedge clk);
    mute = mu; req = r;
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clk);
      req = '0;
      if (beep_en === 1'b1) begin
        if (first_on < 0) first_on = k;
        n_on++;
      end
      if (done === 1'b1 && done_c < 0) done_c = k;
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) begin
        idle_c = k;
        break;
      end
    end
    mute = 1'b0;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       mute;
    int         first_on;
    int         n_on;
    int         done_c;
    int         idle_c;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int fo, no, dc, ic, hits;
    vecs[0] = '{3'b100, 1'b0, 2,  500,  502,  1502};
    vecs[1] = '{3'b010, 1'b0, 2,  2000, 3002, 4002};
    vecs[2] = '{3'b001, 1'b0, 2,  6000, 10002, 11002};
    vecs[3] = '{3'b001, 1'b1, -1, 0,    10002, 11002};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst beep_en", 32'(beep_en), 0);
    check("rst grant",   32'(grant),   0);
    check("rst busy",    32'(busy),    0);
    check("rst done",    32'(done),    0);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      measure(vecs[i].req, vecs[i].mute, fo, no, dc, ic);
      check($sformatf("vec%0d first_on", i), 32'(fo), 32'(vecs[i].first_on));
      check($sformatf("vec%0d on_cycles", i), 32'(no), 32'(vecs[i].n_on));
      check($sformatf("vec%0d done_cyc", i), 32'(dc), 32'(vecs[i].done_c));
      check($sformatf("vec%0d idle_cyc", i), 32'(ic), 32'(vecs[i].idle_c));
    end

    // Same-cycle requests: over-temp first, under-temp after the arbitration cycle.
    @(negedge clk); rc = 0; req = 3'b011;
    adv_to(1); req = '0;
    adv_to(2);     check("dual grant0", 32'(grant), 32'b001);
    adv_to(11002); check("dual gap idle busy", 32'(busy), 0);
    adv_to(11003); check("dual grant1", 32'(grant), 32'b010);
                   check("dual job1 on", 32'(beep_en), 1);
    adv_to(14003); check("dual job1 done", 32'(done), 1);
    adv_to(15003); check("dual end busy", 32'(busy), 0);

    // No preemption, then clr mid second burst with a key request pending.
    @(negedge clk); rc = 0; req = 3'b100;
    adv_to(1);    req = '0;
    adv_to(100);  req = 3'b001;
    adv_to(101);  req = '0;
    adv_to(502);  check("nopre done", 32'(done), 1);
                  check("nopre grant", 32'(grant), 32'b100);
    adv_to(1501); check("nopre gap grant", 32'(grant), 32'b100);
    adv_to(1502); check("nopre idle", 32'(busy), 0);
    adv_to(1503); check("nopre job0 grant", 32'(grant), 32'b001);
    adv_to(5502); check("job0 off end", 32'(beep_en), 0);
    adv_to(5503); check("job0 burst2 on", 32'(beep_en), 1);
    adv_to(5600); req = 3'b100;
    adv_to(5601); req = '0;
    adv_to(6000); clr = 1'b1; req = 3'b010;
    adv_to(6001); clr = 1'b0; req = '0;
    check("clr beep_en", 32'(beep_en), 0);
    check("clr grant",   32'(grant),   0);
    check("clr busy",    32'(busy),    0);
    check("clr done",    32'(done),    0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || beep_en) hits++;
    end
    check("clr drops pending", 32'(hits), 0);

    // Async reset during OFF, then a fresh key-click job.
    @(negedge clk); rc = 0; req = 3'b010;
    adv_to(1); req = '0;
    adv_to(1500);
    check("pre-rst busy", 32'(busy), 1);
    check("pre-rst off",  32'(beep_en), 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst beep_en", 32'(beep_en), 0);
    check("arst grant",   32'(grant),   0);
    check("arst busy",    32'(busy),    0);
    check("arst done",    32'(done),    0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    measure(3'b100, 1'b0, fo, no, dc, ic);
    check("post-rst first_on", 32'(fo), 32'(vecs[0].first_on));
    check("post-rst on_cycles", 32'(no), 32'(vecs[0].n_on));
    check("post-rst done_cyc", 32'(dc), 32'(vecs[0].done_c));
    check("post-rst idle_cyc", 32'(ic), 32'(vecs[0].idle_c));

    // Random traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      req[0] = ($urandom_range(599) == 0);
      req[1] = ($urandom_range(599) == 0);
      req[2] = ($urandom_range(599) == 0);
      if ($urandom_range(399) == 0) mute = ~mute;
      clr = ($urandom_range(2499) == 0);
    end
    @(negedge clk);
    req = '0; clr = 1'b0; mute = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
